// File: rtl/scoreboard_register_file.sv
// ============================================================================
// scoreboard_register_file
// ----------------------------------------------------------------------------
// Purpose:
//   Register file for the ARM-style pipeline. It has two combinational read
//   ports, one synchronous write port and a one-bit-per-register busy
//   scoreboard. ID uses the scoreboard to detect RAW hazards, and WB clears
//   it. A read of PcIndex returns pcIn. A read of any other index outside the
//   physical range returns zero.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   When REGFILE_BYPASS_EN is defined, a same-cycle WB write to a register
//   that is being read is forwarded to the read data. That source is also
//   removed from the hazard term for the cycle. When the macro is undefined,
//   reads return stored contents only.
//
// Parameters:
//   WordLen  data width
//   AddrLen  register index width
//   NumRegs  physical registers 0..NumRegs-1 (NumRegs < 2**AddrLen)
//   PcIndex  index aliased to pcIn (PcIndex >= NumRegs)
//
// Ports:
//   clk            in   clock, rising edge
//   rstN           in   asynchronous active-low reset
//   readRegister1  in   read port 1 index
//   readRegister2  in   read port 2 index
//   src1Valid      in   port 1 index is a real source operand
//   src2Valid      in   port 2 index is a real source operand
//   readData1      out  port 1 data (combinational)
//   readData2      out  port 2 data (combinational)
//   pcIn           in   value returned for reads of PcIndex
//   issueEn        in   instruction with a destination leaves ID
//   issueRegister  in   destination index of the issuing instruction
//   writeEn        in   WB write strobe
//   writeRegister  in   WB destination index
//   writeData      in   WB data
//   flush          in   clear all busy bits (an issue in the same cycle wins)
//   hazard         out  a valid source operand is busy
//   busyVec        out  busy bit per physical register
// ============================================================================
module scoreboard_register_file #(
    parameter int WordLen = 32,
    parameter int AddrLen = 4,
    parameter int NumRegs = 15,
    parameter int PcIndex = 15
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [AddrLen-1:0] readRegister1,
    input  logic [AddrLen-1:0] readRegister2,
    input  logic               src1Valid,
    input  logic               src2Valid,
    output logic [WordLen-1:0] readData1,
    output logic [WordLen-1:0] readData2,
    input  logic [WordLen-1:0] pcIn,
    input  logic               issueEn,
    input  logic [AddrLen-1:0] issueRegister,
    input  logic               writeEn,
    input  logic [AddrLen-1:0] writeRegister,
    input  logic [WordLen-1:0] writeData,
    input  logic               flush,
    output logic               hazard,
    output logic [NumRegs-1:0] busyVec
);

    localparam logic [AddrLen-1:0] NumRegsIdx = AddrLen'(NumRegs);
    localparam logic [AddrLen-1:0] PcIdx      = AddrLen'(PcIndex);

    logic [WordLen-1:0] regFile_r [NumRegs];
    logic [NumRegs-1:0] busy_r;
    logic [NumRegs-1:0] busyNext_s;
    logic               writeHit_s;
    logic               issueHit_s;
    logic [WordLen-1:0] stored1_s;
    logic [WordLen-1:0] stored2_s;
    logic               fwd1_s;
    logic               fwd2_s;
    logic               busy1_s;
    logic               busy2_s;

    // Looks up a busy bit without indexing out of range. Non-physical indices,
    // including PcIndex, are never busy.
    function automatic logic busyAt(input logic [NumRegs-1:0] vec,
                                    input logic [AddrLen-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (idx == AddrLen'(i)) begin
                hit = vec[i];
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Writes and issues take effect only when they target a physical register.
    assign writeHit_s = writeEn && (writeRegister < NumRegsIdx);
    assign issueHit_s = issueEn && (issueRegister < NumRegsIdx);

`ifdef REGFILE_BYPASS_EN
    // A WB write to the register being read forwards its data this cycle.
    assign fwd1_s = writeHit_s && (writeRegister == readRegister1);
    assign fwd2_s = writeHit_s && (writeRegister == readRegister2);
`else
    assign fwd1_s = 1'b0;
    assign fwd2_s = 1'b0;
`endif

    // Stored-content read mux for port 1: the PC alias has priority, and other
    // non-physical indices read as zero.
    always_comb begin
        stored1_s = {WordLen{1'b0}};
        if (readRegister1 == PcIdx) begin
            stored1_s = pcIn;
        end else if (readRegister1 < NumRegsIdx) begin
            stored1_s = regFile_r[readRegister1];
        end else begin
            stored1_s = {WordLen{1'b0}};
        end
    end

    // Stored-content read mux for port 2 (same rules as port 1).
    always_comb begin
        stored2_s = {WordLen{1'b0}};
        if (readRegister2 == PcIdx) begin
            stored2_s = pcIn;
        end else if (readRegister2 < NumRegsIdx) begin
            stored2_s = regFile_r[readRegister2];
        end else begin
            stored2_s = {WordLen{1'b0}};
        end
    end

    assign readData1 = fwd1_s ? writeData : stored1_s;
    assign readData2 = fwd2_s ? writeData : stored2_s;

    // A forwarded source has its RAW hazard resolved in the same cycle.
    assign busy1_s = busyAt(busy_r, readRegister1) & ~fwd1_s;
    assign busy2_s = busyAt(busy_r, readRegister2) & ~fwd2_s;
    assign hazard  = (src1Valid & busy1_s) | (src2Valid & busy2_s);
    assign busyVec = busy_r;

    // Next-state scoreboard. The order flush -> WB clear -> issue set lets a
    // younger issue win over both a flush and a WB to the same register.
    always_comb begin
        busyNext_s = busy_r;
        if (flush) begin
            busyNext_s = {NumRegs{1'b0}};
        end else begin
            busyNext_s = busy_r;
        end
        for (int i = 0; i < NumRegs; i++) begin
            if (writeHit_s && (writeRegister == AddrLen'(i))) begin
                busyNext_s[i] = 1'b0;
            end else begin
                busyNext_s[i] = busyNext_s[i];
            end
            if (issueHit_s && (issueRegister == AddrLen'(i))) begin
                busyNext_s[i] = 1'b1;
            end else begin
                busyNext_s[i] = busyNext_s[i];
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy_r <= {NumRegs{1'b0}};
        end else begin
            busy_r <= busyNext_s;
        end
    end

    // Register storage. Reset loads each register with its own index.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NumRegs; i++) begin
                regFile_r[i] <= WordLen'(i);
            end
        end else if (writeHit_s) begin
            regFile_r[writeRegister] <= writeData;
        end
    end

    scoreboard_register_file_checker #(
        .NumRegs (NumRegs)
    ) uChecker (
        .clk       (clk),
        .rstN      (rstN),
        .flush     (flush),
        .issueEn   (issueEn),
        .src1Valid (src1Valid),
        .src2Valid (src2Valid),
        .hazard    (hazard),
        .busyVec   (busyVec)
    );

endmodule

// ============================================================================
// scoreboard_register_file_checker
// ----------------------------------------------------------------------------
// Purpose:
//   Structural properties of the scoreboard outputs.
//
// Ports:
//   clk, rstN, flush, issueEn, src1Valid, src2Valid, hazard, busyVec
//   All are inputs observed from the register file.
// ============================================================================
module scoreboard_register_file_checker #(
    parameter int NumRegs = 15
) (
    input logic               clk,
    input logic               rstN,
    input logic               flush,
    input logic               issueEn,
    input logic               src1Valid,
    input logic               src2Valid,
    input logic               hazard,
    input logic [NumRegs-1:0] busyVec
);

    // A flush with no competing issue leaves an empty scoreboard.
    aFlushClears: assert property (@(posedge clk) disable iff (!rstN)
        (flush && !issueEn) |=> (busyVec == {NumRegs{1'b0}}));

    // A hazard requires at least one qualified source.
    aHazardQualified: assert property (@(posedge clk) disable iff (!rstN)
        hazard |-> (src1Valid || src2Valid));

    // An empty scoreboard can never raise a hazard.
    aNoBusyNoHazard: assert property (@(posedge clk) disable iff (!rstN)
        (busyVec == {NumRegs{1'b0}}) |-> !hazard);

endmodule

// File: tb/tb_scoreboard_register_file.sv
// ============================================================================
// tb_scoreboard_register_file
// ----------------------------------------------------------------------------
// Directed scenarios, then randomized traffic. All checks compare against a
// behavioural model: an array of register values plus an array of busy flags,
// which is updated once per clock from the specified rules.
// ============================================================================
module tb_scoreboard_register_file;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  readRegister1, readRegister2;
    logic        src1Valid, src2Valid;
    logic [31:0] readData1, readData2;
    logic [31:0] pcIn;
    logic        issueEn;
    logic [3:0]  issueRegister;
    logic        writeEn;
    logic [3:0]  writeRegister;
    logic [31:0] writeData;
    logic        flush;
    logic        hazard;
    logic [14:0] busyVec;

    int testsRun  = 0;
    int failCount = 0;

    // Behavioural model state.
    logic [31:0] mReg  [15];
    logic        mBusy [15];

    scoreboard_register_file dut (
        .clk           (clk),
        .rstN          (rstN),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .src1Valid     (src1Valid),
        .src2Valid     (src2Valid),
        .readData1     (readData1),
        .readData2     (readData2),
        .pcIn          (pcIn),
        .issueEn       (issueEn),
        .issueRegister (issueRegister),
        .writeEn       (writeEn),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .flush         (flush),
        .hazard        (hazard),
        .busyVec       (busyVec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void mReset();
        for (int i = 0; i < 15; i++) begin
            mReg[i]  = 32'(i);
            mBusy[i] = 1'b0;
        end
    endfunction

    function automatic logic mFwd(input logic [3:0] idx);
`ifdef REGFILE_BYPASS_EN
        return writeEn && (writeRegister < 4'd15) && (writeRegister == idx);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mRead(input logic [3:0] idx);
        if (mFwd(idx)) return writeData;
        if (idx == 4'd15) return pcIn;
        return mReg[idx];
    endfunction

    function automatic logic mSrcBusy(input logic [3:0] idx);
        if (idx >= 4'd15) return 1'b0;
        return mBusy[idx] && !mFwd(idx);
    endfunction

    function automatic logic [14:0] mBusyVec();
        logic [14:0] v;
        for (int i = 0; i < 15; i++) v[i] = mBusy[i];
        return v;
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    function automatic void mClock();
        if (flush) begin
            for (int i = 0; i < 15; i++) mBusy[i] = 1'b0;
        end
        if (writeEn && writeRegister < 4'd15) begin
            mReg[writeRegister]  = writeData;
            mBusy[writeRegister] = 1'b0;
        end
        if (issueEn && issueRegister < 4'd15) mBusy[issueRegister] = 1'b1;
    endfunction

    task automatic checkAll(input string tag);
        #1;
        check($sformatf("%s.rd1", tag), readData1, mRead(readRegister1));
        check($sformatf("%s.rd2", tag), readData2, mRead(readRegister2));
        check($sformatf("%s.hz", tag), {31'b0, hazard},
              {31'b0, (src1Valid && mSrcBusy(readRegister1)) ||
                      (src2Valid && mSrcBusy(readRegister2))});
        check($sformatf("%s.busy", tag), {17'b0, busyVec}, {17'b0, mBusyVec()});
    endtask

    task automatic tick();
        @(posedge clk);
        mClock();
        @(negedge clk);
    endtask

    task automatic idle();
        issueEn = 1'b0; writeEn = 1'b0; flush = 1'b0;
        src1Valid = 1'b0; src2Valid = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; idle();
        readRegister1 = 4'd0; readRegister2 = 4'd0; pcIn = 32'h100;
        issueRegister = 4'd0; writeRegister = 4'd0; writeData = 32'h0;
        mReset();
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // 1: reset contents, PC alias, no hazard.
        for (int i = 0; i < 15; i++) begin
            readRegister1 = 4'(i); readRegister2 = 4'(14 - i);
            #1;
            check("rst.val", readData1, 32'(i));
        end
        readRegister1 = 4'd15; src1Valid = 1'b1;
        #1;
        check("rst.pc", readData1, 32'h100);
        check("rst.hz", {31'b0, hazard}, 32'h0);
        check("rst.busy", {17'b0, busyVec}, 32'h0);
        idle();

        // 2: write reg 3, then ignored write to PcIndex.
        writeEn = 1'b1; writeRegister = 4'd3; writeData = 32'hDEAD_BEEF;
        checkAll("wr3");
        tick(); idle();
        readRegister1 = 4'd3;
        #1;
        check("wr3.read", readData1, 32'hDEAD_BEEF);
        writeEn = 1'b1; writeRegister = 4'd15; writeData = 32'h1234_5678;
        readRegister2 = 4'd15;
        checkAll("wr15");
        tick(); idle();
        for (int i = 0; i < 15; i++) begin
            readRegister1 = 4'(i);
            checkAll("wr15.keep");
        end

        // 3: issue 5 -> hazard; WB of 5 clears it.
        issueEn = 1'b1; issueRegister = 4'd5;
        tick(); idle();
        src1Valid = 1'b1; readRegister1 = 4'd5;
        #1;
        check("iss5.hz", {31'b0, hazard}, 32'h1);
        check("iss5.busy", {31'b0, busyVec[5]}, 32'h1);
        writeEn = 1'b1; writeRegister = 4'd5; writeData = 32'h0000_0555;
        checkAll("wb5");
        tick(); idle();
        src1Valid = 1'b1; readRegister1 = 4'd5;
        #1;
        check("wb5.hz", {31'b0, hazard}, 32'h0);
        idle();

        // 4: issue and write reg 7 on the same edge.
        issueEn = 1'b1; issueRegister = 4'd7;
        writeEn = 1'b1; writeRegister = 4'd7; writeData = 32'h55;
        tick(); idle();
        readRegister1 = 4'd7;
        #1;
        check("same7.busy", {31'b0, busyVec[7]}, 32'h1);
        check("same7.read", readData1, 32'h55);

        // 5: busy 2 and 4, then flush with issue 6.
        issueEn = 1'b1; issueRegister = 4'd2; tick();
        issueRegister = 4'd4; tick();
        flush = 1'b1; issueRegister = 4'd6; tick(); idle();
        #1;
        check("flush.busy", {17'b0, busyVec}, 32'h0000_0040);

        // 6: WB to a busy register that is being read.
        issueEn = 1'b1; issueRegister = 4'd9; tick(); idle();
        src1Valid = 1'b1; readRegister1 = 4'd9;
        writeEn = 1'b1; writeRegister = 4'd9; writeData = 32'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp.rd", readData1, 32'hA5);
        check("byp.hz", {31'b0, hazard}, 32'h0);
`else
        check("byp.rd", readData1, 32'h9);
        check("byp.hz", {31'b0, hazard}, 32'h1);
`endif
        tick(); writeEn = 1'b0;
        #1;
        check("byp.next.rd", readData1, 32'hA5);
        check("byp.next.hz", {31'b0, hazard}, 32'h0);
        idle();

        // 7: asynchronous reset mid-cycle discards a pending write.
        issueEn = 1'b1; issueRegister = 4'd1;
        writeEn = 1'b1; writeRegister = 4'd3; writeData = 32'hFFFF_0000;
        readRegister1 = 4'd3; readRegister2 = 4'd9;
        #2;
        rstN = 1'b0;
        mReset();
        #1;
        check("arst.rd1", readData1, 32'h3);
        check("arst.rd2", readData2, 32'h9);
        check("arst.busy", {17'b0, busyVec}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rstN = 1'b1;
        checkAll("arst.after");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            readRegister1 = 4'($urandom);
            readRegister2 = 4'($urandom);
            src1Valid     = 1'($urandom);
            src2Valid     = 1'($urandom);
            pcIn          = $urandom;
            issueEn       = ($urandom_range(0, 2) != 0);
            issueRegister = 4'($urandom);
            writeEn       = ($urandom_range(0, 2) != 0);
            writeRegister = ($urandom_range(0, 3) == 0) ? readRegister1 : 4'($urandom);
            writeData     = $urandom;
            flush         = ($urandom_range(0, 15) == 0);
            checkAll("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
